// File: rtl/wbuf_pkg.sv
// Shared types and AXI encodings for the dcache dirty-line write buffer.
package wbuf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } drain_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/wbuf_tag_match.sv
// DEPTH-way tag comparator; among masked entries that match, reports the one
// closest to the tail (youngest) by scanning outward from the head.
module wbuf_tag_match #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 27,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [DEPTH-1:0]            mask,
  input  logic [PTR_W-1:0]            head,
  input  logic [TAG_W-1:0]            probe,
  output logic                        hit,
  output logic [PTR_W-1:0]            idx
);

  logic [PTR_W-1:0] pos_s;
  logic             sel_s;

  // Oldest-to-youngest scan: a later match overrides an earlier one
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    pos_s = '0;
    sel_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      pos_s = head + PTR_W'(k);
      sel_s = mask[pos_s] & (tags[pos_s] == probe);
      hit   = hit | sel_s;
      idx   = sel_s ? pos_s : idx;
    end
  end

endmodule

// File: rtl/dcache_wbuffer_axi.sv
// Dirty-line write buffer: circular FIFO of evicted lines with coalescing and
// refill forwarding, drained one AXI3 INCR burst per line in the background.
module dcache_wbuffer_axi
  import wbuf_pkg::*;
#(
  parameter int         DEPTH      = 8,
  parameter int         LINE_WORDS = 8,
  parameter int         ADDR_W     = 32,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wreq,
  output logic                       wack,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [LINE_WORDS*32-1:0]   wdata,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic [LINE_WORDS*32-1:0]   lookup_data,
  output logic                       full,
  output logic                       empty,
  input  logic                       clear,
  output logic                       clear_done,
  output logic                       bus_err,
  output logic [3:0]                 awid,
  output logic [ADDR_W-1:0]          awaddr,
  output logic [3:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic [1:0]                 awlock,
  output logic [3:0]                 awcache,
  output logic [2:0]                 awprot,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [3:0]                 wid,
  // AXI W-channel beat data; the name wdata is taken by the line input
  output logic [31:0]                axi_wdata,
  output logic [3:0]                 wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [3:0]                 bid,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready
);

  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int LINE_W = LINE_WORDS * 32;

  logic [DEPTH-1:0][TAG_W-1:0]  tag_r;
  logic [DEPTH-1:0][LINE_W-1:0] data_r;
  logic [DEPTH-1:0]             valid_r;
  logic [PTR_W-1:0]             head_r, tail_r;
  logic [CNT_W-1:0]             count_r;
  logic [BEAT_W-1:0]            beat_r;
  logic                         bus_err_r, clear_pend_r;
  drain_state_e                 state_r, state_nxt;

  logic              inflight_s, co_hit_s, lk_hit_s, alloc_s, co_write_s, pop_s, last_beat_s;
  logic [PTR_W-1:0]  co_idx_s, lk_idx_s;
  logic [DEPTH-1:0]  head_oh_s, co_mask_s;
  logic              unused_s;

  // Once AW is accepted the head line is committed to the bus and must not change
  assign inflight_s = (state_r == W) | (state_r == B);
  assign head_oh_s  = DEPTH'(1) << head_r;
  assign co_mask_s  = valid_r & ~(inflight_s ? head_oh_s : {DEPTH{1'b0}});

  wbuf_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PTR_W(PTR_W)) u_match_enq (
    .tags  (tag_r),
    .mask  (co_mask_s),
    .head  (head_r),
    .probe (waddr[ADDR_W-1:OFF_W]),
    .hit   (co_hit_s),
    .idx   (co_idx_s)
  );

  wbuf_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PTR_W(PTR_W)) u_match_lookup (
    .tags  (tag_r),
    .mask  (valid_r),
    .head  (head_r),
    .probe (lookup_addr[ADDR_W-1:OFF_W]),
    .hit   (lk_hit_s),
    .idx   (lk_idx_s)
  );

  assign full        = (count_r == CNT_W'(DEPTH));
  assign empty       = (count_r == {CNT_W{1'b0}});
  assign wack        = wreq & (co_hit_s | ~full);
  assign alloc_s     = wreq & ~co_hit_s & ~full;
  assign co_write_s  = wreq & co_hit_s;
  assign pop_s       = (state_r == B) & bvalid;
  assign last_beat_s = (beat_r == BEAT_W'(LINE_WORDS - 1));

  // Queue bookkeeping: valid bits, pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_r <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_W'(1);
      end
      if (alloc_s) begin
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(alloc_s) - CNT_W'(pop_s);
    end
  end

  // Line storage: allocate at tail or overwrite the matching queued entry
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      tag_r[tail_r]  <= waddr[ADDR_W-1:OFF_W];
      data_r[tail_r] <= wdata;
    end else if (co_write_s) begin
      data_r[co_idx_s] <= wdata;
    end
  end

  // Drain state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= IDLE;
    else       state_r <= state_nxt;
  end

  // Drain next-state: one burst outstanding, AW strictly before W
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    state_nxt = empty ? IDLE : AW;
      AW:      state_nxt = awready ? W : AW;
      W:       state_nxt = (wready && last_beat_s) ? B : W;
      B:       state_nxt = bvalid ? IDLE : B;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat index within the current burst
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          beat_r <= '0;
    else if (state_r == W && wready)    beat_r <= last_beat_s ? '0 : beat_r + BEAT_W'(1);
  end

  // Sticky error flag and pending clear request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_err_r    <= 1'b0;
      clear_pend_r <= 1'b0;
    end else begin
      if (pop_s && (bresp != AXI_RESP_OKAY)) bus_err_r <= 1'b1;
      if (clear_done)  clear_pend_r <= 1'b0;
      else if (clear)  clear_pend_r <= 1'b1;
    end
  end

  assign bus_err     = bus_err_r;
  assign clear_done  = clear_pend_r & empty & (state_r == IDLE);
  assign lookup_hit  = lk_hit_s;
  assign lookup_data = lk_hit_s ? data_r[lk_idx_s] : {LINE_W{1'b0}};

  // Channel fields are zeroed outside their valid phase so idle outputs read 0
  assign awvalid   = (state_r == AW);
  assign awid      = awvalid ? AXI_ID : 4'd0;
  assign awaddr    = awvalid ? {tag_r[head_r], {OFF_W{1'b0}}} : {ADDR_W{1'b0}};
  assign awlen     = awvalid ? 4'(LINE_WORDS - 1) : 4'd0;
  assign awsize    = awvalid ? AXI_SIZE_4B : 3'd0;
  assign awburst   = awvalid ? AXI_BURST_INCR : 2'd0;
  assign awlock    = 2'd0;
  assign awcache   = 4'd0;
  assign awprot    = 3'd0;
  assign wvalid    = (state_r == W);
  assign wid       = wvalid ? AXI_ID : 4'd0;
  assign axi_wdata = wvalid ? data_r[head_r][{beat_r, 5'd0} +: 32] : 32'd0;
  assign wstrb     = wvalid ? 4'hF : 4'h0;
  assign wlast     = wvalid & last_beat_s;
  assign bready    = (state_r == B);

  assign unused_s = ^{waddr[OFF_W-1:0], lookup_addr[OFF_W-1:0], bid};

endmodule

// File: tb/tb_dcache_wbuffer_axi.sv
// Scoreboard bench for dcache_wbuffer_axi: expected bursts are queued at enqueue
// time and checked beat by beat as the DUT drains them.
module tb_dcache_wbuffer_axi;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         wreq = 1'b0;
  logic         wack;
  logic [31:0]  waddr = 32'd0;
  logic [255:0] wdata = 256'd0;
  logic [31:0]  lookup_addr = 32'd0;
  logic         lookup_hit;
  logic [255:0] lookup_data;
  logic         full, empty, clear_done, bus_err;
  logic         clear = 1'b0;
  logic [3:0]   awid, awlen, awcache, wid, wstrb;
  logic [31:0]  awaddr, axi_wdata;
  logic [2:0]   awsize, awprot;
  logic [1:0]   awburst, awlock;
  logic         awvalid, wlast, wvalid, bready;
  logic         awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]   bid = 4'd1;
  logic [1:0]   bresp = 2'b00;

  int errors = 0;
  int checks = 0;
  logic [31:0]  exp_addr_q[$];
  logic [255:0] exp_line_q[$];
  logic [31:0]  exp_a;
  logic [255:0] cur_line = 256'd0;
  int beat = 0;
  int beats_seen = 0;

  always #5 clk = ~clk;

  dcache_wbuffer_axi dut (
    .clk(clk), .rstn(rstn), .wreq(wreq), .wack(wack), .waddr(waddr), .wdata(wdata),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .full(full), .empty(empty), .clear(clear), .clear_done(clear_done), .bus_err(bus_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .axi_wdata(axi_wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Burst monitor: pops the scoreboard on each AW handshake, checks every W beat
  always @(negedge clk) begin
    if (rstn) begin
      if (awvalid && awready) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL aw_unexpected awaddr=%h with empty scoreboard", awaddr);
        end else begin
          exp_a    = exp_addr_q.pop_front();
          cur_line = exp_line_q.pop_front();
          beat     = 0;
          if (awaddr !== exp_a || awlen !== 4'd7 || awsize !== 3'b010 || awburst !== 2'b01 ||
              awid !== 4'd1 || wvalid !== 1'b0) begin
            errors++;
            $display("FAIL aw_fields addr=%h len=%0d size=%0d burst=%0d id=%0d wvalid=%b expected addr=%h len=7 size=2 burst=1 id=1 wvalid=0",
                     awaddr, awlen, awsize, awburst, awid, wvalid, exp_a);
          end
        end
      end
      if (wvalid && wready) begin
        checks++;
        if (axi_wdata !== cur_line[beat*32 +: 32] || wlast !== (beat == 7) || wstrb !== 4'hF) begin
          errors++;
          $display("FAIL w_beat%0d data=%h wlast=%b wstrb=%h expected data=%h wlast=%b wstrb=f",
                   beat, axi_wdata, wlast, wstrb, cur_line[beat*32 +: 32], (beat == 7));
        end
        beat++;
        beats_seen++;
      end
    end
  end

  function automatic logic [255:0] mkline(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [255:0] d, input bit push);
    int n;
    n = 0;
    waddr = a; wdata = d; wreq = 1'b1;
    @(negedge clk);
    while (!wack && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wack !== 1'b1) begin
      errors++;
      $display("FAIL enq_accept addr=%h wack=%b expected 1", a, wack);
    end else if (push) begin
      exp_addr_q.push_back(a & ~32'h1F);
      exp_line_q.push_back(d);
    end
    tick();
    wreq = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!empty && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (empty !== 1'b1 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain empty=%b pending=%0d expected empty=1 pending=0", name, empty, exp_addr_q.size());
    end
    tick();
  endtask

  task automatic wait_sig(input string name, input int which);
    int n;
    n = 0;
    @(negedge clk);
    while (((which == 0) ? !awvalid : (which == 1) ? !wvalid : !bready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_timeout awvalid=%b wvalid=%b bready=%b expected handshake phase", name, awvalid, wvalid, bready);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    exp_addr_q.delete();
    exp_line_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({empty, full, awvalid, wvalid, bready, bus_err, clear_done, lookup_hit, wack} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_flags empty=%b full=%b awv=%b wv=%b br=%b err=%b cd=%b hit=%b wack=%b expected empty=1 rest 0",
               empty, full, awvalid, wvalid, bready, bus_err, clear_done, lookup_hit, wack);
    end
    checks++;
    if (awaddr !== 32'd0 || awlen !== 4'd0 || axi_wdata !== 32'd0 || lookup_data !== 256'd0) begin
      errors++;
      $display("FAIL reset_buses awaddr=%h awlen=%0d wdata=%h lkdata_nz=%b expected all 0", awaddr, awlen, axi_wdata, |lookup_data);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int b0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    b0 = beats_seen;
    enq(32'h1000, mkline(32'd0), 1'b1);
    @(negedge clk);
    checks++;
    if (awvalid !== 1'b0) begin errors++; $display("FAIL single_aw_early awvalid=%b expected 0", awvalid); end
    @(negedge clk);
    checks++;
    if (awvalid !== 1'b1 || awaddr !== 32'h1000) begin
      errors++;
      $display("FAIL single_aw_latency awvalid=%b awaddr=%h expected 1 00001000", awvalid, awaddr);
    end
    wait_empty("single");
    checks++;
    if (beats_seen - b0 != 8) begin errors++; $display("FAIL single_beats got=%0d expected 8", beats_seen - b0); end
  endtask

  task automatic test_full_coalesce();
    logic [255:0] nl;
    awready = 1'b0;
    for (int k = 0; k < 8; k++) enq(32'h10000 + 32'(k) * 32'h100, mkline(32'h100 * 32'(k + 1)), 1'b1);
    @(negedge clk);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_flag full=%b expected 1", full); end
    tick();
    waddr = 32'h10800; wdata = mkline(32'hDEAD0); wreq = 1'b1;
    @(negedge clk);
    checks++;
    if (wack !== 1'b0) begin errors++; $display("FAIL full_reject wack=%b expected 0", wack); end
    tick();
    wreq = 1'b0;
    nl = mkline(32'hA000);
    enq(32'h10304, nl, 1'b0);
    exp_line_q[3] = nl;
    @(negedge clk);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL coalesce_count full=%b expected 1", full); end
    tick();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    wait_empty("full_coalesce");
  endtask

  task automatic test_lookup();
    logic [255:0] la, lb;
    la = mkline(32'hB000);
    lb = mkline(32'hC000);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    enq(32'h2000, la, 1'b1);
    lookup_addr = 32'h2008;
    @(negedge clk);
    checks++;
    if (lookup_hit !== 1'b1 || lookup_data !== la) begin
      errors++;
      $display("FAIL lookup_queued hit=%b word0=%h expected 1 %h", lookup_hit, lookup_data[31:0], la[31:0]);
    end
    lookup_addr = 32'h3000;
    @(negedge clk);
    checks++;
    if (lookup_hit !== 1'b0 || lookup_data !== 256'd0) begin
      errors++;
      $display("FAIL lookup_miss hit=%b word0=%h expected 0 0", lookup_hit, lookup_data[31:0]);
    end
    tick();
    awready = 1'b1;
    wait_sig("lookup_aw", 0);
    tick();
    awready = 1'b0;
    lookup_addr = 32'h2000;
    @(negedge clk);
    checks++;
    if (lookup_hit !== 1'b1 || lookup_data !== la) begin
      errors++;
      $display("FAIL lookup_inflight hit=%b word0=%h expected 1 %h", lookup_hit, lookup_data[31:0], la[31:0]);
    end
    tick();
    enq(32'h2000, lb, 1'b1);
    @(negedge clk);
    checks++;
    if (lookup_hit !== 1'b1 || lookup_data !== lb || empty !== 1'b0) begin
      errors++;
      $display("FAIL lookup_youngest hit=%b word0=%h empty=%b expected 1 %h 0", lookup_hit, lookup_data[31:0], empty, lb[31:0]);
    end
    tick();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    wait_empty("lookup");
  endtask

  task automatic test_wrap();
    logic [255:0] l7;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
    do_reset();
    for (int k = 0; k < 7; k++) enq(32'h20000 + 32'(k) * 32'h40, mkline(32'h1000 * 32'(k) + 32'h55), 1'b1);
    awready = 1'b1;
    wait_sig("wrap_b", 2);
    tick();
    l7 = mkline(32'hE000);
    bvalid = 1'b1; awready = 1'b0;
    waddr = 32'h20400; wdata = l7; wreq = 1'b1;
    @(negedge clk);
    checks++;
    if (wack !== 1'b1 || bready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_simul wack=%b bready=%b expected 1 1", wack, bready);
    end else begin
      exp_addr_q.push_back(32'h20400);
      exp_line_q.push_back(l7);
    end
    tick();
    wreq = 1'b0; bvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (full !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL wrap_count full=%b empty=%b expected 0 0", full, empty);
    end
    tick();
    enq(32'h20440, mkline(32'hF000), 1'b1);
    @(negedge clk);
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL wrap_full full=%b expected 1", full); end
    tick();
    awready = 1'b1; bvalid = 1'b1;
    wait_empty("wrap");
  endtask

  task automatic test_clear();
    int pulses, pulse_cyc, empty_cyc;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
    for (int k = 0; k < 4; k++) enq(32'h30000 + 32'(k) * 32'h20, mkline(32'h7000 + 32'(k) * 32'h10), 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    awready = 1'b1;
    pulses = 0; pulse_cyc = -1; empty_cyc = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (clear_done) begin
        pulses++;
        if (pulse_cyc < 0) pulse_cyc = c;
      end
      if (empty && empty_cyc < 0) empty_cyc = c;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL clear_pulses got=%0d expected 1", pulses); end
    checks++;
    if (empty_cyc < 0 || pulse_cyc != empty_cyc) begin
      errors++;
      $display("FAIL clear_timing pulse_cycle=%0d expected empty_cycle=%0d", pulse_cyc, empty_cyc);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin errors++; $display("FAIL clear_drain pending=%0d expected 0", exp_addr_q.size()); end
    tick();
    clear = 1'b1;
    @(negedge clk);
    checks++;
    if (clear_done !== 1'b0) begin errors++; $display("FAIL clear_empty_early clear_done=%b expected 0", clear_done); end
    tick();
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (clear_done !== 1'b1) begin errors++; $display("FAIL clear_empty_pulse clear_done=%b expected 1", clear_done); end
    @(negedge clk);
    checks++;
    if (clear_done !== 1'b0) begin errors++; $display("FAIL clear_empty_drop clear_done=%b expected 0", clear_done); end
    tick();
  endtask

  task automatic test_bus_err_reset();
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
    enq(32'h40000, mkline(32'h9000), 1'b1);
    enq(32'h40020, mkline(32'h9100), 1'b1);
    awready = 1'b1;
    wait_sig("buserr_b", 2);
    tick();
    bresp = 2'b00;
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_set bus_err=%b expected 1", bus_err); end
    tick();
    wait_empty("bus_err");
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky bus_err=%b expected 1", bus_err); end
    tick();
    wready = 1'b0;
    enq(32'h50000, mkline(32'h5000), 1'b1);
    wait_sig("reset_w", 1);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (wvalid !== 1'b0 || awvalid !== 1'b0 || empty !== 1'b1 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_midburst wvalid=%b awvalid=%b empty=%b bus_err=%b expected 0 0 1 0", wvalid, awvalid, empty, bus_err);
    end
    exp_addr_q.delete();
    exp_line_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || wvalid !== 1'b0 || awvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release empty=%b wvalid=%b awvalid=%b expected 1 0 0", empty, wvalid, awvalid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_coalesce();
    test_lookup();
    test_wrap();
    test_clear();
    test_bus_err_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
